snitch_icache_data_ctrl: RTL and testbench

SNITCH_ICACHE_DATA_CTRL -- requirements
Module: snitch_icache_data_ctrl

---
 rtl/snitch_icache_data_ctrl.sv | 164 ++++++++++++++++
 tb/tb_snitch_icache_data_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_icache_data_ctrl.sv
// Instruction cache data array controller.
// Arbitrates lookups (reads) and refills (writes) onto a single SRAM port and
// returns read data through a small IDLE/READ/HOLD response FSM.
// Optional lookup fairness: define SNITCH_ICACHE_DATA_CTRL_FAIR_EN.
module snitch_icache_data_ctrl #(
  parameter int SET_COUNT  = 2,
  parameter int LINE_WIDTH = 128,
  parameter int LINE_COUNT = 128,
  localparam int AW = $clog2(LINE_COUNT),
  localparam int WW = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            lookup_valid_i,
  output logic                            lookup_ready_o,
  input  logic [AW-1:0]                   lookup_addr_i,
  input  logic [SET_COUNT-1:0]            lookup_way_i,
  input  logic                            refill_valid_i,
  output logic                            refill_ready_o,
  input  logic [AW-1:0]                   refill_addr_i,
  input  logic [WW-1:0]                   refill_way_i,
  input  logic [LINE_WIDTH-1:0]           refill_data_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [LINE_WIDTH-1:0]           rsp_data_o,
  output logic [SET_COUNT-1:0]            ram_enable_o,
  output logic                            ram_write_o,
  output logic [AW-1:0]                   ram_addr_o,
  output logic [SET_COUNT*LINE_WIDTH-1:0] ram_wdata_o,
  input  logic [SET_COUNT*LINE_WIDTH-1:0] ram_rdata_i
);

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_e;

  state_e                state_reg, state_next;
  logic [SET_COUNT-1:0]  way_reg;
  logic [LINE_WIDTH-1:0] hold_reg;
  logic                  capture_hold;

  logic                  lookup_ok;
  logic                  fair_force;
  logic                  lookup_grant;
  logic                  refill_grant;

  logic [SET_COUNT-1:0]  refill_onehot;
  logic [LINE_WIDTH-1:0] masked_rdata [SET_COUNT];
  logic [LINE_WIDTH-1:0] read_data;

  // A new lookup may start whenever the response path is free or draining.
  assign lookup_ok = (state_reg == IDLE) || rsp_ready_i;

`ifdef SNITCH_ICACHE_DATA_CTRL_FAIR_EN
  logic [1:0] fair_cnt_reg, fair_cnt_next;

  assign fair_force = (fair_cnt_reg == 2'd3);

  // Count refills that starved a waiting lookup; saturate at 3.
  always_comb begin
    fair_cnt_next = fair_cnt_reg;
    if (lookup_grant || !lookup_valid_i) begin
      fair_cnt_next = 2'd0;
    end else if (refill_grant && fair_cnt_reg != 2'd3) begin
      fair_cnt_next = fair_cnt_reg + 2'd1;
    end
  end

  // Fairness counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fair_cnt_reg <= 2'd0;
    end else begin
      fair_cnt_reg <= fair_cnt_next;
    end
  end
`else
  assign fair_force = 1'b0;
`endif

  // Refill wins a conflict unless fairness forces the lookup through.
  assign lookup_grant   = lookup_valid_i && lookup_ok && (!refill_valid_i || fair_force);
  assign refill_grant   = refill_valid_i && !lookup_grant;
  assign lookup_ready_o = lookup_ok && !refill_grant;
  assign refill_ready_o = !lookup_grant;

  // Per-way decode of the refill victim, replicated write data, and read masking.
  genvar gi;
  generate
    for (gi = 0; gi < SET_COUNT; gi++) begin : g_way
      assign refill_onehot[gi] = (refill_way_i == WW'(gi));
      assign ram_wdata_o[gi*LINE_WIDTH +: LINE_WIDTH] = refill_data_i;
      assign masked_rdata[gi] = way_reg[gi] ? ram_rdata_i[gi*LINE_WIDTH +: LINE_WIDTH]
                                            : '0;
    end
  endgenerate

  // Single SRAM port driven straight from whichever request is granted.
  always_comb begin
    ram_enable_o = '0;
    ram_write_o  = 1'b0;
    ram_addr_o   = '0;
    if (refill_grant) begin
      ram_enable_o = refill_onehot;
      ram_write_o  = 1'b1;
      ram_addr_o   = refill_addr_i;
    end else if (lookup_grant) begin
      ram_enable_o = lookup_way_i;
      ram_addr_o   = lookup_addr_i;
    end
  end

  // OR the masked way outputs; an empty way mask yields an all-zero line.
  always_comb begin
    read_data = '0;
    for (int i = 0; i < SET_COUNT; i++) begin
      read_data = read_data | masked_rdata[i];
    end
  end

  // Response FSM next state and outputs.
  always_comb begin
    state_next   = state_reg;
    capture_hold = 1'b0;
    rsp_valid_o  = 1'b0;
    rsp_data_o   = '0;
    case (state_reg)
      IDLE: begin
        if (lookup_grant) state_next = READ;
      end
      READ: begin
        rsp_valid_o = 1'b1;
        rsp_data_o  = read_data;
        if (rsp_ready_i) begin
          state_next = lookup_grant ? READ : IDLE;
        end else begin
          // SRAM output is only guaranteed this cycle, so park it.
          state_next   = HOLD;
          capture_hold = 1'b1;
        end
      end
      HOLD: begin
        rsp_valid_o = 1'b1;
        rsp_data_o  = hold_reg;
        if (rsp_ready_i) begin
          state_next = lookup_grant ? READ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, registered lookup way and hold register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      way_reg   <= '0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (lookup_grant) way_reg <= lookup_way_i;
      if (capture_hold) hold_reg <= read_data;
    end
  end

endmodule

// File: tb/tb_snitch_icache_data_ctrl.sv
// Directed bench for snitch_icache_data_ctrl with a behavioural SRAM and a
// queue of expected responses.
module tb_snitch_icache_data_ctrl;

`ifdef SNITCH_ICACHE_DATA_CTRL_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         lookup_valid_i, lookup_ready_o;
  logic [6:0]   lookup_addr_i;
  logic [1:0]   lookup_way_i;
  logic         refill_valid_i, refill_ready_o;
  logic [6:0]   refill_addr_i;
  logic [0:0]   refill_way_i;
  logic [127:0] refill_data_i;
  logic         rsp_valid_o, rsp_ready_i;
  logic [127:0] rsp_data_o;
  logic [1:0]   ram_enable_o;
  logic         ram_write_o;
  logic [6:0]   ram_addr_o;
  logic [255:0] ram_wdata_o;
  logic [255:0] ram_rdata_i;

  int checks = 0;
  int errors = 0;
  int hs     = 0;
  logic [127:0] exp_q [$];
  logic [127:0] exp_mem [2][128];

  snitch_icache_data_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .lookup_valid_i (lookup_valid_i),
    .lookup_ready_o (lookup_ready_o),
    .lookup_addr_i  (lookup_addr_i),
    .lookup_way_i   (lookup_way_i),
    .refill_valid_i (refill_valid_i),
    .refill_ready_o (refill_ready_o),
    .refill_addr_i  (refill_addr_i),
    .refill_way_i   (refill_way_i),
    .refill_data_i  (refill_data_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_data_o     (rsp_data_o),
    .ram_enable_o   (ram_enable_o),
    .ram_write_o    (ram_write_o),
    .ram_addr_o     (ram_addr_o),
    .ram_wdata_o    (ram_wdata_o),
    .ram_rdata_i    (ram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [127:0] line_val(int w, int l);
    logic [7:0] wb;
    logic [7:0] lb;
    wb = 8'(w);
    lb = 8'(l);
    return {wb, lb, 112'h0123456789ABCDEF001122334455};
  endfunction

  // Behavioural SRAM: 1-cycle read latency, output holds between reads.
  logic [127:0] sram [2][128];
  bit           written [2][128];
  logic [127:0] rdata_w [2];

  always @(posedge clk_i) begin
    for (int w = 0; w < 2; w++) begin
      if (ram_enable_o[w]) begin
        if (ram_write_o) begin
          sram[w][ram_addr_o]    <= ram_wdata_o[w*128 +: 128];
          written[w][ram_addr_o] <= 1'b1;
        end else begin
          rdata_w[w] <= written[w][ram_addr_o] ? sram[w][ram_addr_o]
                                               : line_val(w, int'(ram_addr_o));
        end
      end
    end
  end
  assign ram_rdata_i = {rdata_w[1], rdata_w[0]};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: on the negedge retire any response handshake against the queue.
  task automatic cyc();
    logic [127:0] e;
    @(negedge clk_i);
    if (rsp_valid_o && rsp_ready_i) begin
      hs++;
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 256'(1), 256'(0));
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", 256'(rsp_data_o), 256'(e));
        $display("rsp: data=%h expected=%h", rsp_data_o, e);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int h0;
    int nref;
    logic [127:0] old;
    logic [127:0] rd;
    bit lg;

    for (int w = 0; w < 2; w++)
      for (int l = 0; l < 128; l++)
        exp_mem[w][l] = line_val(w, l);

    rst_ni = 1'b0;
    lookup_valid_i = 1'b0; lookup_addr_i = '0; lookup_way_i = '0;
    refill_valid_i = 1'b0; refill_addr_i = '0; refill_way_i = '0; refill_data_i = '0;
    rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_rsp_valid", 256'(rsp_valid_o), 256'(0));
    chk("rst_enable", 256'(ram_enable_o), 256'(0));
    chk("rst_write", 256'(ram_write_o), 256'(0));
    rst_ni = 1'b1;
    cyc();
    chk("idle_lookup_ready", 256'(lookup_ready_o), 256'(1));
    chk("idle_refill_ready", 256'(refill_ready_o), 256'(1));

    // Lookup line 5 way 1.
    lookup_valid_i = 1'b1; lookup_addr_i = 7'd5; lookup_way_i = 2'b10;
    #1;
    chk("lk_enable", 256'(ram_enable_o), 256'(2'b10));
    chk("lk_addr", 256'(ram_addr_o), 256'(5));
    chk("lk_write", 256'(ram_write_o), 256'(0));
    chk("lk_lookup_ready", 256'(lookup_ready_o), 256'(1));
    chk("lk_refill_ready", 256'(refill_ready_o), 256'(0));
    $display("lookup: addr=5 way=10");
    exp_q.push_back(exp_mem[1][5]);
    cyc();
    lookup_valid_i = 1'b0;
    #1;
    chk("lk_latency_valid", 256'(rsp_valid_o), 256'(1));
    cyc();
    chk("lk_after_valid", 256'(rsp_valid_o), 256'(0));

    // Refill line 7 way 0, then read it back.
    rd = {16{8'hA5}};
    refill_valid_i = 1'b1; refill_addr_i = 7'd7; refill_way_i = 1'b0; refill_data_i = rd;
    #1;
    chk("rf_write", 256'(ram_write_o), 256'(1));
    chk("rf_enable", 256'(ram_enable_o), 256'(2'b01));
    chk("rf_addr", 256'(ram_addr_o), 256'(7));
    chk("rf_wdata", ram_wdata_o, {rd, rd});
    chk("rf_refill_ready", 256'(refill_ready_o), 256'(1));
    chk("rf_lookup_ready", 256'(lookup_ready_o), 256'(0));
    $display("refill: addr=7 way=0 data=%h", rd);
    exp_mem[0][7] = rd;
    cyc();
    refill_valid_i = 1'b0;
    lookup_valid_i = 1'b1; lookup_addr_i = 7'd7; lookup_way_i = 2'b01;
    exp_q.push_back(exp_mem[0][7]);
    cyc();
    lookup_valid_i = 1'b0;
    cyc();

    // Back-to-back lookups at full rate.
    h0 = hs;
    for (int i = 0; i < 4; i++) begin
      lookup_valid_i = 1'b1;
      lookup_addr_i  = 7'(i + 1);
      lookup_way_i   = (i % 2 == 1) ? 2'b10 : 2'b01;
      #1;
      chk("b2b_lookup_ready", 256'(lookup_ready_o), 256'(1));
      exp_q.push_back(exp_mem[(i % 2 == 1) ? 1 : 0][i + 1]);
      cyc();
    end
    lookup_valid_i = 1'b0;
    cyc();
    chk("b2b_handshakes", 256'(hs - h0), 256'(4));

    // Stall with a refill to the same line: held data must not change.
    h0 = hs;
    old = exp_mem[0][9];
    lookup_valid_i = 1'b1; lookup_addr_i = 7'd9; lookup_way_i = 2'b01;
    exp_q.push_back(old);
    cyc();
    lookup_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    rd = {16{8'h5A}};
    refill_valid_i = 1'b1; refill_addr_i = 7'd9; refill_way_i = 1'b0; refill_data_i = rd;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_valid", 256'(rsp_valid_o), 256'(1));
      chk("stall_data", 256'(rsp_data_o), 256'(old));
      chk("stall_lookup_ready", 256'(lookup_ready_o), 256'(0));
      chk("stall_refill_ready", 256'(refill_ready_o), 256'(1));
      cyc();
      if (k == 0) begin
        refill_valid_i = 1'b0;
        exp_mem[0][9] = rd;
      end
    end
    rsp_ready_i = 1'b1;
    #1;
    chk("hold_release_data", 256'(rsp_data_o), 256'(old));
    cyc();
    chk("hold_after_valid", 256'(rsp_valid_o), 256'(0));
    chk("hold_handshakes", 256'(hs - h0), 256'(1));
    lookup_valid_i = 1'b1; lookup_addr_i = 7'd9; lookup_way_i = 2'b01;
    exp_q.push_back(exp_mem[0][9]);
    cyc();
    lookup_valid_i = 1'b0;
    cyc();

    // Lookup with no way selected.
    h0 = hs;
    lookup_valid_i = 1'b1; lookup_addr_i = 7'd3; lookup_way_i = 2'b00;
    #1;
    chk("way0_enable", 256'(ram_enable_o), 256'(0));
    exp_q.push_back('0);
    cyc();
    lookup_valid_i = 1'b0;
    cyc();
    chk("way0_handshakes", 256'(hs - h0), 256'(1));

    // Conflict: both valid for five cycles.
    nref = 0;
    rd = {16{8'h3C}};
    lookup_valid_i = 1'b1; lookup_addr_i = 7'd4; lookup_way_i = 2'b01;
    refill_valid_i = 1'b1; refill_addr_i = 7'd20; refill_way_i = 1'b1; refill_data_i = rd;
    for (int k = 0; k < 5; k++) begin
      #1;
      lg = FAIR && (k == 3);
      chk("conf_lookup_ready", 256'(lookup_ready_o), 256'(lg));
      chk("conf_refill_ready", 256'(refill_ready_o), 256'(!lg));
      if (lg) exp_q.push_back(exp_mem[0][4]);
      nref += int'(ram_write_o);
      $display("conflict: cycle=%0d write=%0d lookup_ready=%0d", k, ram_write_o, lookup_ready_o);
      cyc();
    end
    lookup_valid_i = 1'b0;
    refill_valid_i = 1'b0;
    exp_mem[1][20] = rd;
    chk("conf_refills", 256'(nref), FAIR ? 256'(4) : 256'(5));
    cyc();
    cyc();

    // Reset while holding a response.
    lookup_valid_i = 1'b1; lookup_addr_i = 7'd11; lookup_way_i = 2'b10;
    rsp_ready_i = 1'b0;
    exp_q.push_back(exp_mem[1][11]);
    cyc();
    lookup_valid_i = 1'b0;
    cyc();
    chk("pre_reset_valid", 256'(rsp_valid_o), 256'(1));
    rst_ni = 1'b0;
    #1;
    chk("reset_valid", 256'(rsp_valid_o), 256'(0));
    chk("reset_enable", 256'(ram_enable_o), 256'(0));
    exp_q.delete();
    cyc();
    rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("post_reset_valid", 256'(rsp_valid_o), 256'(0));
      cyc();
    end

    chk("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
